// File: rtl/cart_scan_ctrl.sv
// Cartridge scan controller: streams ROM bytes from memory into a
// bankswitch/Superchip detector, then latches the detector verdict.
module cart_scan_ctrl #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] rom_size,
  input  logic [3:0]  user_bs,
  output logic        mem_req,
  output logic [12:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [12:0] det_addr,
  output logic        det_enable,
  output logic [7:0]  det_data,
  input  logic [3:0]  det_force_bs,
  input  logic        det_sc,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bs_out,
  output logic        sc_out
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FEED,
    ST_FLUSH,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [12:0]   a_q, a_d;
  logic [13:0]   n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [12:0]   mem_addr_q, mem_addr_d;
  logic          det_enable_q, det_enable_d;
  logic [12:0]   det_addr_q, det_addr_d;
  logic [7:0]    det_data_q, det_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    bs_q, bs_d;
  logic          sc_q, sc_d;

  logic [13:0]   n_eff;
  logic [13:0]   a_next_wide;

  // Scan length is capped at the 8 KiB detector window.
  always_comb begin
    n_eff       = (rom_size > 14'd8192) ? 14'd8192 : rom_size;
    a_next_wide = {1'b0, a_q} + 14'd1;
  end

  // Next-state and registered-output computation.
  // Outputs are computed alongside the next state so every output is a flop.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    det_enable_d = det_enable_q;
    det_addr_d   = det_addr_q;
    det_data_d   = det_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    bs_d         = bs_q;
    sc_d         = sc_q;

    if (state_q != ST_IDLE && abort) begin
      // Abort wins over everything, including a coincident mem_ack.
      state_d      = ST_IDLE;
      mem_req_d    = 1'b0;
      det_enable_d = 1'b0;
      busy_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            n_d    = n_eff;
            busy_d = 1'b1;
            if (n_eff == 14'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_REQ;
              a_d        = '0;
              mem_req_d  = 1'b1;
              mem_addr_d = '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_d      = ST_FEED;
            mem_req_d    = 1'b0;
            det_enable_d = 1'b1;
            det_addr_d   = a_q;
            det_data_d   = mem_data;
          end
        end
        ST_FEED: begin
          a_d = a_q + 13'd1;
          if (a_next_wide < n_q) begin
            state_d      = ST_REQ;
            mem_req_d    = 1'b1;
            mem_addr_d   = a_q + 13'd1;
            det_enable_d = 1'b0;
          end else begin
            state_d    = ST_FLUSH;
            det_addr_d = '1;
            det_data_d = '0;
          end
        end
        ST_FLUSH: begin
          det_enable_d = 1'b0;
          cnt_d        = '0;
          if (SETTLE == 0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          bs_d    = (user_bs != 4'd0) ? user_bs : det_force_bs;
          sc_d    = (n_q != 14'd0) && det_sc;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      det_enable_q <= 1'b0;
      det_addr_q   <= '0;
      det_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bs_q         <= '0;
      sc_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      det_enable_q <= det_enable_d;
      det_addr_q   <= det_addr_d;
      det_data_q   <= det_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bs_q         <= bs_d;
      sc_q         <= sc_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign det_enable = det_enable_q;
  assign det_addr   = det_addr_q;
  assign det_data   = det_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bs_out     = bs_q;
  assign sc_out     = sc_q;

endmodule

// File: tb/tb_cart_scan_ctrl.sv
// Bench for cart_scan_ctrl: ROM responder, scan-level reference model,
// per-cycle output compare, directed scenarios and a randomized phase.
module tb_cart_scan_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset_n, start, abort;
  logic [13:0] rom_size;
  logic [3:0]  user_bs;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [12:0] det_addr;
  logic        det_enable;
  logic [7:0]  det_data;
  logic [3:0]  det_force_bs;
  logic        det_sc;
  logic        busy, done;
  logic [3:0]  bs_out;
  logic        sc_out;

  cart_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rom_size(rom_size), .user_bs(user_bs),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .det_addr(det_addr), .det_enable(det_enable), .det_data(det_data),
    .det_force_bs(det_force_bs), .det_sc(det_sc),
    .busy(busy), .done(done), .bs_out(bs_out), .sc_out(sc_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ROM responder ----------------
  logic [7:0] rom [8192];
  int  lat = 0;
  bit  lat_rand = 0;
  bit  spur_en = 0;
  int  stall_addr = -1;
  int  w = 0;
  int  cur_lat = 0;

  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        w       = 0;
        cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_ack  = 1'b1;
          mem_data = 8'($urandom);
        end else begin
          mem_ack = 1'b0;
        end
      end else if (stall_addr >= 0 && int'(mem_addr) == stall_addr) begin
        mem_ack = 1'b0;
      end else if (w >= cur_lat) begin
        mem_ack  = 1'b1;
        mem_data = rom[mem_addr];
        w        = 0;
      end else begin
        mem_ack = 1'b0;
        w++;
      end
    end
  end

  // ---------------- Reference model ----------------
  // Expected outputs for the next cycle, derived from the scan rules:
  // request each address in turn, one detector beat per returned byte,
  // a flush beat, SETTLE quiet cycles, one done cycle, then latch results.
  logic        e_req = 0, e_en = 0, e_busy = 0, e_done = 0, e_sc = 0;
  logic [12:0] e_maddr = '0, e_daddr = '0;
  logic [7:0]  e_ddata = '0;
  logic [3:0]  e_bs = '0;
  bit          m_active = 0, m_wait = 0, m_fed = 0, m_flush = 0;
  int          m_addr = 0, m_n = 0, m_left = 0;
  int          n_now;

  always_comb n_now = (int'(rom_size) > 8192) ? 8192 : int'(rom_size);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_req <= 0; e_en <= 0; e_busy <= 0; e_done <= 0; e_sc <= 0;
      e_maddr <= '0; e_daddr <= '0; e_ddata <= '0; e_bs <= '0;
      m_active <= 0; m_wait <= 0; m_fed <= 0; m_flush <= 0;
      m_addr <= 0; m_n <= 0; m_left <= 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active <= 1;
        e_busy   <= 1;
        m_n      <= n_now;
        if (n_now == 0) begin
          e_done <= 1;
        end else begin
          m_wait  <= 1;
          m_addr  <= 0;
          e_req   <= 1;
          e_maddr <= '0;
        end
      end
    end else if (abort) begin
      m_active <= 0; m_wait <= 0; m_fed <= 0; m_flush <= 0; m_left <= 0;
      e_busy <= 0; e_req <= 0; e_en <= 0; e_done <= 0;
    end else if (e_done) begin
      e_done   <= 0;
      e_busy   <= 0;
      m_active <= 0;
      e_bs     <= (user_bs != 0) ? user_bs : det_force_bs;
      e_sc     <= (m_n != 0) && det_sc;
    end else if (m_wait) begin
      if (mem_ack) begin
        m_wait  <= 0;
        e_req   <= 0;
        e_en    <= 1;
        e_daddr <= 13'(m_addr);
        e_ddata <= mem_data;
        m_fed   <= 1;
      end
    end else if (m_fed) begin
      m_fed <= 0;
      if (m_addr + 1 < m_n) begin
        m_addr  <= m_addr + 1;
        m_wait  <= 1;
        e_req   <= 1;
        e_maddr <= 13'(m_addr + 1);
        e_en    <= 0;
      end else begin
        e_daddr <= 13'h1FFF;
        e_ddata <= 8'h00;
        m_flush <= 1;
      end
    end else if (m_flush) begin
      m_flush <= 0;
      e_en    <= 0;
      if (SETTLE == 0) e_done <= 1;
      else m_left <= SETTLE;
    end else begin
      if (m_left <= 1) begin
        m_left <= 0;
        e_done <= 1;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // ---------------- Per-cycle compare and monitor ----------------
  int beats, zero_cnt, done_cnt, req_cnt, done_cyc, last_beat_cyc;
  int last_addr, prev_addr, last_data, first_addr;

  task automatic clear_mon();
    beats = 0; zero_cnt = 0; done_cnt = 0; req_cnt = 0;
    done_cyc = -1; last_beat_cyc = -1;
    last_addr = 0; prev_addr = 0; last_data = 0; first_addr = -1;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      check("mem_req",    mem_req,    e_req);
      check("mem_addr",   mem_addr,   e_maddr);
      check("det_enable", det_enable, e_en);
      check("det_addr",   det_addr,   e_daddr);
      check("det_data",   det_data,   e_ddata);
      check("busy",       busy,       e_busy);
      check("done",       done,       e_done);
      check("bs_out",     bs_out,     e_bs);
      check("sc_out",     sc_out,     e_sc);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_req === 1'b1) req_cnt++;
      if (det_enable === 1'b1) begin
        if (beats == 0) first_addr = int'(det_addr);
        beats++;
        prev_addr     = last_addr;
        last_addr     = int'(det_addr);
        last_data     = int'(det_data);
        last_beat_cyc = cyc;
        if (det_addr == 13'd0) zero_cnt++;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  int st_cyc;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    tick();
    start  = 1'b1;
    st_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_finish"}, ok, 1);
  endtask

  task automatic wait_req_at(input int addr, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && int'(mem_addr) == addr) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic wait_feed_at(input int addr, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (det_enable === 1'b1 && int'(det_addr) == addr) begin
        found = 1;
        break;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  // ---------------- Scenarios ----------------
  initial begin : main
    bit found;
    int bad;
    reset_n = 1'b1; start = 1'b0; abort = 1'b0;
    rom_size = '0; user_bs = '0; det_force_bs = '0; det_sc = 1'b0;
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", {mem_req, mem_addr, det_enable, det_addr, det_data,
                            busy, done, bs_out, sc_out}, 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // 4 KiB image, detector reports type 4.
    rom_size = 14'd4096; user_bs = 4'd0; det_force_bs = 4'd4; det_sc = 1'b0;
    clear_mon();
    pulse_start();
    wait_idle(20000, "scan4096");
    check("s4k_beats", beats, 4097);
    check("s4k_last_feed", prev_addr, 4095);
    check("s4k_flush_addr", last_addr, 13'h1FFF);
    check("s4k_flush_data", last_data, 0);
    check("s4k_done_delay", done_cyc - last_beat_cyc, SETTLE + 1);
    check("s4k_done_cnt", done_cnt, 1);
    check("s4k_addr0_once", zero_cnt, 1);
    check("s4k_bs", bs_out, 4'd4);
    check("s4k_sc", sc_out, 1'b0);

    // Empty image: straight to done, no memory traffic.
    rom_size = 14'd0; user_bs = 4'hA; det_sc = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle(10, "scan0");
    check("s0_done_cycle", done_cyc, st_cyc + 1);
    check("s0_done_cnt", done_cnt, 1);
    check("s0_no_req", req_cnt, 0);
    check("s0_no_beats", beats, 0);
    check("s0_bs", bs_out, 4'hA);
    check("s0_sc", sc_out, 1'b0);

    // Oversized image clipped to 8 KiB.
    rom_size = 14'd12000; user_bs = 4'd0; det_force_bs = 4'd2; det_sc = 1'b0;
    clear_mon();
    pulse_start();
    wait_idle(40000, "scan8k");
    check("s8k_beats", beats, 8193);
    check("s8k_last_feed", prev_addr, 13'h1FFF);
    check("s8k_flush_addr", last_addr, 13'h1FFF);
    check("s8k_addr0_once", zero_cnt, 1);
    check("s8k_bs", bs_out, 4'd2);

    // Extension-forced type overrides the detector.
    rom_size = 14'd64; user_bs = 4'd6; det_force_bs = 4'd3; det_sc = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle(1000, "scan_user");
    check("user_bs_wins", bs_out, 4'd6);
    check("user_sc", sc_out, 1'b1);

    // Abort while requesting address 100, coincident with mem_ack.
    rom_size = 14'd1000; user_bs = 4'd0; det_force_bs = 4'd5; det_sc = 1'b0;
    stall_addr = 100;
    clear_mon();
    pulse_start();
    wait_req_at(100, 2000, found);
    check("abort_reach_100", found, 1);
    repeat (3) tick();
    stall_addr = -1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 1'b0);
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_no_feed100", beats, 100);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_bs_kept", bs_out, 4'd6);
    check("abort_sc_kept", sc_out, 1'b1);

    rom_size = 14'd2048; det_force_bs = 4'd9; det_sc = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle(10000, "scan2048");
    check("s2k_first_addr", first_addr, 0);
    check("s2k_beats", beats, 2049);
    check("s2k_last_feed", prev_addr, 2047);
    check("s2k_done_cnt", done_cnt, 1);
    check("s2k_bs", bs_out, 4'd9);
    check("s2k_sc", sc_out, 1'b1);

    // Reset in the middle of a detector beat.
    rom_size = 14'd300; det_force_bs = 4'd1;
    clear_mon();
    pulse_start();
    wait_feed_at(37, 2000, found);
    check("rst_reach_feed37", found, 1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_clear", {mem_req, mem_addr, det_enable, det_addr, det_data,
                              busy, done, bs_out, sc_out}, 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    check("rst_stays_idle", {mem_req, mem_addr, det_enable, det_addr, det_data,
                             busy, done, bs_out, sc_out}, 64'd0);

    // Memory stall of 50 cycles with a start pulse while busy.
    rom_size = 14'd20; user_bs = 4'd0; det_force_bs = 4'd7; det_sc = 1'b0;
    stall_addr = 5;
    clear_mon();
    pulse_start();
    wait_req_at(5, 500, found);
    check("stall_reach_5", found, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(mem_req === 1'b1 && mem_addr === 13'd5)) bad++;
      if (i == 25) start = 1'b1;
      if (i == 26) start = 1'b0;
    end
    check("stall_req_held", bad, 0);
    stall_addr = -1;
    wait_idle(500, "scan_stall");
    check("stall_beats", beats, 21);
    check("stall_first_addr", first_addr, 0);
    check("stall_addr0_once", zero_cnt, 1);
    check("stall_done_cnt", done_cnt, 1);
    check("stall_bs", bs_out, 4'd7);

    // Randomized scans: variable latency, stray acks, random abort and start.
    spur_en  = 1;
    lat_rand = 1;
    for (int s = 0; s < 40; s++) begin
      rom_size     = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(0, 1))
                                                 : 14'($urandom_range(2, 48));
      user_bs      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      det_force_bs = 4'($urandom);
      det_sc       = 1'($urandom);
      pulse_start();
      for (int c = 0; c < 2000; c++) begin
        tick();
        start = 1'b0;
        abort = 1'b0;
        if (busy === 1'b0) break;
        det_force_bs = 4'($urandom);
        det_sc       = 1'($urandom);
        abort        = ($urandom_range(0, 99) == 0);
        start        = ($urandom_range(0, 19) == 0);
      end
      start = 1'b0;
      abort = 1'b0;
      wait_idle(3000, "rand_scan");
    end
    spur_en  = 0;
    lat_rand = 0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
